// File: rtl/fc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// fc_ctrl_pkg : constants and state type shared by the FC-layer controllers
// Rev 1.0
// ============================================================================
package fc_ctrl_pkg;

   localparam int N_CLASSES   = 10;
   localparam int SCORE_W     = 16;
   localparam int CLASS_IDX_W = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage
`default_nettype wire

// File: rtl/argmax_seq_ctrl.sv
`default_nettype none
// ============================================================================
// argmax_seq_ctrl : scans N_CLASSES scores with one comparator, returns argmax
// Rev 1.0
// ============================================================================
module argmax_seq_ctrl
   import fc_ctrl_pkg::*;
#(
   parameter int N_CLASSES = fc_ctrl_pkg::N_CLASSES,
   parameter int DATA_W    = fc_ctrl_pkg::SCORE_W,
   parameter int IDX_W     = fc_ctrl_pkg::CLASS_IDX_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              rd_en,
   output logic [IDX_W-1:0]  rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [IDX_W-1:0]  classified,
   output logic [DATA_W-1:0] max_val
);

   localparam logic [IDX_W-1:0] LAST_ADDR = IDX_W'(N_CLASSES - 1);

   state_t            state;
   logic              data_vld;
   logic [DATA_W-1:0] run_max;
   logic [IDX_W-1:0]  run_idx;
   logic [IDX_W-1:0]  data_idx;
   logic              take;

   // Strict compare: an equal later score never displaces the earlier index.
   assign take = data_vld && (rd_data > run_max);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         busy       <= 1'b0;
         rd_en      <= 1'b0;
         rd_addr    <= '0;
         res_valid  <= 1'b0;
         classified <= '0;
         max_val    <= '0;
         data_vld   <= 1'b0;
         run_max    <= '0;
         run_idx    <= '0;
         data_idx   <= '0;
      end else begin
         data_vld <= rd_en;
         if (take) begin
            run_max <= rd_data;
            run_idx <= data_idx;
         end
         if (data_vld) begin
            data_idx <= data_idx + IDX_W'(1);
         end

         case (state)
            IDLE: begin
               run_max  <= '0;
               run_idx  <= '0;
               rd_addr  <= '0;
               data_idx <= '0;
               if (start) begin
                  state <= READ;
                  busy  <= 1'b1;
                  rd_en <= 1'b1;
               end
            end
            READ: begin
               if (rd_addr == LAST_ADDR) begin
                  rd_en <= 1'b0;
                  state <= DRAIN;
               end else begin
                  rd_addr <= rd_addr + IDX_W'(1);
               end
            end
            DRAIN: begin
               // Last score is on rd_data now; fold it in while committing.
               classified <= take ? data_idx : run_idx;
               max_val    <= take ? rd_data : run_max;
               res_valid  <= 1'b1;
               state      <= DONE;
            end
            DONE: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_argmax_seq_ctrl.sv
`default_nettype none
// Randomized bench for argmax_seq_ctrl: behavioural scan model plus literal checks.
module tb_argmax_seq_ctrl;

   localparam int N  = 10;
   localparam int DW = 16;
   localparam int IW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          busy;
   logic          rd_en;
   logic [IW-1:0] rd_addr;
   logic [DW-1:0] rd_data = '0;
   logic          res_valid;
   logic          res_ready = 1'b0;
   logic [IW-1:0] classified;
   logic [DW-1:0] max_val;

   logic [DW-1:0] mem [N];

   int n_cmp = 0;
   int n_mis = 0;

   bit            m_idle = 1'b1;
   int            m_k = 0;
   logic [IW-1:0] m_cls = '0;
   logic [DW-1:0] m_max = '0;

   argmax_seq_ctrl #(.N_CLASSES(N), .DATA_W(DW), .IDX_W(IW)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .res_valid(res_valid), .res_ready(res_ready),
      .classified(classified), .max_val(max_val)
   );

   always #5 clk = ~clk;

   // Score buffer: one-cycle read latency, junk on rd_data otherwise.
   always @(posedge clk) begin
      if (rd_en && rd_addr < IW'(N)) rd_data <= mem[rd_addr];
      else                           rd_data <= DW'($urandom);
   end

   function automatic logic [IW+DW-1:0] ref_argmax();
      logic [DW-1:0] best = '0;
      logic [IW-1:0] bi = '0;
      for (int i = 0; i < N; i++) begin
         if (mem[i] > best) begin
            best = mem[i];
            bi   = IW'(i);
         end
      end
      return {bi, best};
   endfunction

   // Model: m_k counts cycles since start was accepted (0..N-1 read, N drain, N+1 result).
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_idle = 1'b1; m_k = 0; m_cls = '0; m_max = '0;
      end else if (m_idle) begin
         if (start) begin m_idle = 1'b0; m_k = 0; end
      end else if (m_k < N + 1) begin
         m_k++;
         if (m_k == N + 1) {m_cls, m_max} = ref_argmax();
      end else if (res_ready) begin
         m_idle = 1'b1;
      end
   end

   always @(negedge clk) begin
      logic e_busy, e_rden, e_val;
      if (!rst) begin
         e_busy = !m_idle;
         e_rden = !m_idle && (m_k < N);
         e_val  = !m_idle && (m_k == N + 1);
         n_cmp++;
         if (busy !== e_busy || rd_en !== e_rden || (e_rden && rd_addr !== m_k[IW-1:0]) ||
             res_valid !== e_val || classified !== m_cls || max_val !== m_max) begin
            n_mis++;
            $display("FAIL cycle t=%0t: got busy=%b rd_en=%b rd_addr=%0d res_valid=%b cls=%0d max=%h; want busy=%b rd_en=%b rd_addr=%0d res_valid=%b cls=%0d max=%h",
                     $time, busy, rd_en, rd_addr, res_valid, classified, max_val,
                     e_busy, e_rden, m_k, e_val, m_cls, m_max);
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic classify(input int stall, input bit poke,
                           output logic [IW-1:0] cls, output logic [DW-1:0] mv, output int lat);
      @(negedge clk); start = 1'b1; lat = 0;
      @(negedge clk); start = 1'b0; lat = 1;
      while (res_valid !== 1'b1 && lat < 40) begin
         start = poke && (lat % 3 == 0);
         @(negedge clk);
         lat++;
      end
      start = 1'b0;
      if (res_valid !== 1'b1) begin
         n_cmp++; n_mis++;
         $display("FAIL res_valid_timeout: got 0 after %0d cycles want 1", lat);
      end
      cls = classified;
      mv  = max_val;
      for (int i = 0; i < stall; i++) begin
         start = poke;
         @(negedge clk);
      end
      res_ready = 1'b1; start = poke;
      @(negedge clk);
      res_ready = 1'b0; start = 1'b0;
      chk("idle_after_handshake", 32'(busy), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [IW-1:0] cls;
      logic [DW-1:0] mv;
      int lat, nres, waited;
      logic [IW+DW-1:0] r;

      for (int i = 0; i < N; i++) mem[i] = '0;
      repeat (3) @(negedge clk);
      chk("reset_busy", 32'(busy), 0);
      chk("reset_rd_en", 32'(rd_en), 0);
      chk("reset_res_valid", 32'(res_valid), 0);
      chk("reset_result", {12'd0, classified, max_val}, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Ascending ramp
      for (int i = 0; i < N; i++) mem[i] = DW'(i + 1);
      classify(0, 1'b0, cls, mv, lat);
      chk("ramp_latency", lat, 12);
      chk("ramp_cls", 32'(cls), 9);
      chk("ramp_max", 32'(mv), 32'h000A);

      // All zero
      for (int i = 0; i < N; i++) mem[i] = '0;
      classify(0, 1'b0, cls, mv, lat);
      chk("zero_cls", 32'(cls), 0);
      chk("zero_max", 32'(mv), 0);

      // Tie keeps lower index
      for (int i = 0; i < N; i++) mem[i] = 16'h0100;
      mem[3] = 16'h0500; mem[7] = 16'h0500;
      classify(1, 1'b0, cls, mv, lat);
      chk("tie_cls", 32'(cls), 3);
      chk("tie_max", 32'(mv), 32'h0500);

      // Unsigned compare
      for (int i = 0; i < N; i++) mem[i] = 16'h7FFF;
      mem[0] = 16'hFFFF;
      classify(0, 1'b0, cls, mv, lat);
      chk("unsigned_cls", 32'(cls), 0);
      chk("unsigned_max", 32'(mv), 32'hFFFF);

      // Stall with start pokes while busy and at the handshake
      for (int i = 0; i < N; i++) mem[i] = DW'(N - i);
      classify(5, 1'b1, cls, mv, lat);
      chk("stall_cls", 32'(cls), 0);
      chk("stall_max", 32'(mv), 32'h000A);
      repeat (3) @(negedge clk);
      chk("no_extra_result", 32'(busy), 0);

      // Reset mid-scan at rd_addr 4
      for (int i = 0; i < N; i++) mem[i] = DW'(i * 100 + 5);
      mem[6] = 16'h9000;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      waited = 0;
      while (!(rd_en === 1'b1 && rd_addr === 4'd4) && waited < 20) begin
         @(negedge clk); waited++;
      end
      chk("reached_addr4", 32'(rd_en === 1'b1 && rd_addr === 4'd4), 1);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_rd_en", 32'(rd_en), 0);
      chk("mid_rst_rd_addr", 32'(rd_addr), 0);
      chk("mid_rst_result", {11'd0, res_valid, classified, max_val}, 0);
      @(negedge clk); rst = 1'b0;
      classify(0, 1'b0, cls, mv, lat);
      chk("post_rst_cls", 32'(cls), 6);
      chk("post_rst_max", 32'(mv), 32'h9000);

      // Back-to-back throughput: N+3 cycles per result
      @(negedge clk); start = 1'b1; res_ready = 1'b1; nres = 0;
      for (int i = 0; i < 3 * (N + 3); i++) begin
         @(negedge clk);
         if (res_valid === 1'b1) nres++;
      end
      start = 1'b0; res_ready = 1'b0;
      chk("throughput_results", nres, 3);
      repeat (2) @(negedge clk);

      // Randomized scans
      for (int it = 0; it < 40; it++) begin
         int mode;
         mode = $urandom_range(0, 2);
         for (int i = 0; i < N; i++) begin
            if (mode == 0)      mem[i] = DW'($urandom);
            else if (mode == 1) mem[i] = DW'($urandom_range(0, 3));
            else                mem[i] = 16'h4242;
         end
         r = ref_argmax();
         classify($urandom_range(0, 3), 1'($urandom_range(0, 1)), cls, mv, lat);
         chk("rand_result", {12'd0, cls, mv}, {12'd0, r});
      end

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/argmax_seq_ctrl.md
Name: argmax_seq_ctrl

Overview:
- Sequential argmax controller for the output of the second FC layer.
- On `start`, it reads N_CLASSES scores one per cycle from the layer-2 output buffer and tracks the running maximum and its index.
- It presents the winning class index and its score on a valid/ready result port.
- It replaces the combinational 10-way compare with a single comparator, scheduled over N_CLASSES+2 cycles.

Parameters:
- N_CLASSES, 10, number of scores scanned per classification (2..2**IDX_W).
- DATA_W, 16, score width; unsigned.
- IDX_W, 4, class index width.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request one classification; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- rd_en  out  1  score-buffer read strobe.
- rd_addr  out  IDX_W  score-buffer read address.
- rd_data  in  DATA_W  score; valid exactly one cycle after the rd_en cycle.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- classified  out  IDX_W  winning class index.
- max_val  out  DATA_W  winning score.

Behaviour:
- Reset values: state IDLE; busy=0, rd_en=0, rd_addr=0, res_valid=0, classified=0, max_val=0; running max=0, running index=0, address counter=0, data-valid pipe=0.
- States: IDLE, READ, DRAIN, DONE.
- IDLE:
  - start=1 -> READ.
  - Clear the running max to 0, the running index to 0, and the address counter to 0.
- READ:
  - rd_en=1; rd_addr = counter; counter increments each cycle.
  - When rd_addr == N_CLASSES-1 -> DRAIN.
- DRAIN:
  - rd_en=0.
  - Consume the last returned score.
  - Commit the running result to classified/max_val.
  - -> DONE.
- DONE:
  - res_valid=1; classified/max_val held stable.
  - res_valid && res_ready -> IDLE, with res_valid=0 on the next cycle.
- Compare rule:
  - A one-bit pipe marks the cycle after each rd_en; in that cycle rd_data is compared against the running max.
  - Update only if rd_data > running max (strict, unsigned).
  - Ties keep the lower index.
  - Because the running max starts at 0, an all-zero vector yields classified=0, max_val=0.
- Timing: start sampled at edge T0.
  - Addresses 0..N-1 are issued in cycles T1..TN.
  - Score N-1 returns in TN+1 (DRAIN).
  - res_valid rises at TN+2, which is 12 cycles for N=10.
  - Throughput: one classification per N+3 cycles when res_ready is held high.
- classified/max_val change only at the DRAIN->DONE edge. Between results they hold the previous result, not partial values.
- start while busy: ignored; no queuing.
- start in the same cycle as the DONE handshake: ignored; it must be reasserted in IDLE.
- res_ready outside DONE: ignored.
- Reset mid-operation (any state): immediate return to reset values.
  - rd_en drops asynchronously.
  - The partial scan is discarded and no result is produced.
- rd_addr never exceeds N_CLASSES-1; there is no wrap within a scan.
- Arithmetic: comparator is DATA_W-bit unsigned; index registers are IDX_W bits; no overflow is possible.

Decomposition:
- Package fc_ctrl_pkg holds:
  - state typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE};
  - constants N_CLASSES=10, SCORE_W=16, CLASS_IDX_W=4, shared with the FC layer and output buffer.
- Single module; no natural sub-module. The comparator is one line and stays inline.

Test Plan:
- Scores 0x0001..0x000A at addresses 0..9, start pulse -> res_valid at start+12, classified=9, max_val=0x000A.
- All scores 0 -> classified=0, max_val=0.
- Tie: addresses 3 and 7 = 0x0500, others 0x0100 -> classified=3, max_val=0x0500.
- Address 0 = 0xFFFF, others 0x7FFF -> classified=0, max_val=0xFFFF (unsigned compare).
- res_ready low for 5 cycles after res_valid, then high -> outputs stable through the stall; IDLE one cycle after the handshake; start pulses during busy produce no extra result.
- rst asserted at READ with rd_addr=4 -> all outputs 0 immediately; a subsequent start runs a clean full scan with the correct result.
